button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event.sv | 134 +++++++++++++
 tb/tb_button_event.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// rtl/button_event.sv - press/release/long-press/auto-repeat event generator for a debounced button
module button_event #(
    parameter int LONG   = 20,
    parameter int REPEAT = 8,
    parameter int CW     = 19
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clean,
    input  logic       enable,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [CW-1:0] LONG_C   = CW'(LONG);
    localparam logic [CW-1:0] REPEAT_C = CW'(REPEAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    press_count_q, press_count_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    // Next-state, counter and registered-output logic; at most one pulse is set per edge
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_count_d = press_count_q;
        press_d       = 1'b0;
        release_d     = 1'b0;
        long_d        = 1'b0;
        repeat_d      = 1'b0;

        if (!enable) begin
            // A button still down when events are disabled must be released before it counts again
            state_d = clean ? ST_LOCKOUT : ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (clean) begin
                        state_d       = ST_PRESSED;
                        cnt_d         = '0;
                        press_d       = 1'b1;
                        press_count_d = press_count_q + 8'd1;
                    end
                end
                ST_PRESSED: begin
                    if (!clean) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt_q == LONG_C) begin
                        state_d = ST_LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_LONG: begin
                    if (!clean) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt_q == REPEAT_C) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_LOCKOUT: begin
                    if (!clean) begin
                        state_d = ST_IDLE;
                    end
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
    end

    // State, counter and output registers; reset picks LOCKOUT when the button is already down
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= clean ? ST_LOCKOUT : ST_IDLE;
            cnt_q         <= '0;
            press_count_q <= 8'd0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            long_q        <= 1'b0;
            repeat_q      <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_count_q <= press_count_d;
            press_q       <= press_d;
            release_q     <= release_d;
            long_q        <= long_d;
            repeat_q      <= repeat_d;
            held_q        <= held_d;
        end
    end

    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - randomized and directed self-checking bench for button_event
module tb_button_event;

    localparam int LONG   = 20;
    localparam int REPEAT = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clean = 1'b0;
    logic       enable = 1'b1;
    logic       press, release_pulse, long_press, repeat_pulse, held;
    logic [7:0] press_count;

    int tests = 0;
    int failures = 0;

    // Reference model: an accepted hold is tracked by its age in cycles
    bit m_active = 0;
    bit m_locked = 0;
    int m_age = 0;
    int m_count = 0;
    bit e_press, e_release, e_long, e_repeat;

    // Pulse tallies observed from the DUT, cleared per scenario
    int n_press, n_release, n_long, n_repeat, n_held;

    button_event #(.LONG(LONG), .REPEAT(REPEAT), .CW(19)) dut (
        .clock(clock),
        .reset(reset),
        .clean(clean),
        .enable(enable),
        .press(press),
        .release_pulse(release_pulse),
        .long_press(long_press),
        .repeat_pulse(repeat_pulse),
        .held(held),
        .press_count(press_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_edge(input bit c, input bit e, input bit r);
        e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
        if (r) begin
            m_active = 0; m_locked = c; m_count = 0;
        end else if (!e) begin
            m_active = 0; m_locked = c;
        end else if (m_locked) begin
            if (!c) m_locked = 0;
        end else if (!m_active) begin
            if (c) begin
                m_active = 1; m_age = 0; e_press = 1;
                m_count = (m_count + 1) % 256;
            end
        end else if (!c) begin
            m_active = 0; e_release = 1;
        end else begin
            m_age++;
            if (m_age == LONG + 1) e_long = 1;
            else if (m_age > LONG + 1 && (m_age - (LONG + 1)) % (REPEAT + 1) == 0) e_repeat = 1;
        end
    endtask

    task automatic step(input bit c, input bit e, input bit r);
        clean = c; enable = e; reset = r;
        @(posedge clock);
        model_edge(c, e, r);
        #1;
        check("press", press, e_press);
        check("release", release_pulse, e_release);
        check("long_press", long_press, e_long);
        check("repeat", repeat_pulse, e_repeat);
        check("held", held, m_active);
        check("press_count", press_count, m_count);
        check("one_pulse", (press + release_pulse + long_press + repeat_pulse) <= 1, 1);
        n_press   += press;
        n_release += release_pulse;
        n_long    += long_press;
        n_repeat  += repeat_pulse;
        n_held    += held;
    endtask

    task automatic clear_tally();
        n_press = 0; n_release = 0; n_long = 0; n_repeat = 0; n_held = 0;
    endtask

    initial begin
        int long_at, rep_first, rep_last;
        clear_tally();

        // Reset with button up
        step(0, 1, 1);
        step(0, 1, 1);
        check("rst_count", press_count, 0);
        check("rst_held", held, 0);

        // Short press of 5 cycles
        clear_tally();
        repeat (5) step(1, 1, 0);
        repeat (3) step(0, 1, 0);
        check("short_press_n", n_press, 1);
        check("short_release_n", n_release, 1);
        check("short_long_n", n_long, 0);
        check("short_held_n", n_held, 5);
        check("short_count", press_count, 1);

        // Long hold of 60 cycles
        step(0, 1, 1);
        clear_tally();
        long_at = -1; rep_first = -1; rep_last = -1;
        for (int i = 0; i < 60; i++) begin
            step(1, 1, 0);
            if (long_press) long_at = i;
            if (repeat_pulse) begin
                if (rep_first < 0) rep_first = i;
                rep_last = i;
            end
        end
        step(0, 1, 0);
        check("long_rel_no_repeat", repeat_pulse, 0);
        check("long_rel", release_pulse, 1);
        check("long_at", long_at, 21);
        check("long_rep_n", n_repeat, 4);
        check("long_rep_first", rep_first, 30);
        check("long_rep_last", rep_last, 57);

        // Reset while the button is down
        clear_tally();
        step(1, 1, 1);
        step(1, 1, 1);
        repeat (10) step(1, 1, 0);
        check("rstdown_quiet", n_press + n_release + n_long + n_repeat, 0);
        repeat (2) step(0, 1, 0);
        repeat (3) step(1, 1, 0);
        repeat (2) step(0, 1, 0);
        check("rstdown_press_n", n_press, 1);
        check("rstdown_release_n", n_release, 1);
        check("rstdown_count", press_count, 1);

        // Enable gating while in LONG
        clear_tally();
        repeat (25) step(1, 1, 0);
        step(1, 0, 0);
        check("gate_held", held, 0);
        check("gate_no_release", release_pulse, 0);
        repeat (3) step(1, 1, 0);
        check("gate_no_repress", n_press, 1);
        step(0, 1, 0);
        check("gate_release_n", n_release, 0);
        step(1, 1, 0);
        check("gate_repress", press, 1);
        step(0, 1, 0);

        // Press counter wrap
        step(0, 1, 1);
        clear_tally();
        repeat (257) begin
            step(1, 1, 0);
            step(0, 1, 0);
        end
        check("wrap_count", press_count, 1);
        check("wrap_press_n", n_press, 257);
        check("wrap_release_n", n_release, 257);

        // Reset five cycles after long_press
        step(0, 1, 1);
        clear_tally();
        repeat (27) step(1, 1, 0);
        check("midlong_long_n", n_long, 1);
        step(1, 1, 1);
        check("midlong_all_zero", {press, release_pulse, long_press, repeat_pulse, held, press_count}, 0);
        clear_tally();
        repeat (4) step(1, 1, 0);
        repeat (2) step(0, 1, 0);
        check("midlong_no_events", n_press + n_release + n_long + n_repeat, 0);

        // Randomized runs of button levels with occasional disable and reset
        for (int blk = 0; blk < 150; blk++) begin
            bit lvl;
            int len;
            lvl = $urandom_range(1, 0);
            len = $urandom_range(45, 1);
            for (int k = 0; k < len; k++) begin
                step(lvl, ($urandom_range(29, 0) != 0), ($urandom_range(299, 0) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
